// File: rtl/agc_timer_pkg.sv
// agc_timer_pkg: shared timer-group constants for the scaler chain.
//   SCALER_STAGES_DEFAULT  default chain length (FS02..FS18)
//   FSnn_IDX               bit index of stage FSnn within the FS/FA/FB vectors
//   stage_period(k)        period of stage k in advancing FS01_ clocks
package agc_timer_pkg;
    localparam int SCALER_STAGES_DEFAULT = 17;
    localparam int FS02_IDX = 0;
    localparam int FS03_IDX = 1;
    localparam int FS04_IDX = 2;
    localparam int FS05_IDX = 3;
    localparam int FS06_IDX = 4;
    localparam int FS07_IDX = 5;
    localparam int FS08_IDX = 6;
    localparam int FS09_IDX = 7;
    localparam int FS10_IDX = 8;
    localparam int FS11_IDX = 9;
    localparam int FS12_IDX = 10;
    localparam int FS13_IDX = 11;
    localparam int FS14_IDX = 12;
    localparam int FS15_IDX = 13;
    localparam int FS16_IDX = 14;
    localparam int FS17_IDX = 15;
    localparam int FS18_IDX = 16;
    function automatic longint unsigned stage_period(input int k);
        return longint'(1) << (k + 1);
    endfunction
endpackage

// File: rtl/scaler_edge_det.sv
// scaler_edge_det: FA/FB phase-pulse pair for one scaler stage.
//   cur  stage bit before the edge      fa  rising-edge pulse (next value)
//   nxt  stage bit after the edge       fb  falling-edge pulse (next value)
//   adv  chain advances on this edge
module scaler_edge_det (
    input  logic cur,
    input  logic nxt,
    input  logic adv,
    output logic fa,
    output logic fb
);
    assign fa = adv & ~cur & nxt;
    assign fb = adv & cur & ~nxt;
endmodule

// File: rtl/agc_scaler_chain.sv
// agc_scaler_chain: STAGES-deep binary scaler clocked by FS01_ with phase pulses, wrap and tick.
//   FS01_     clock              rst       sync active-low reset
//   en        advance enable     load      preload strobe, load_val its value
//   tap_sel   stage index for tick
//   FS        stage square waves FA/FB     registered rising/falling pulses per stage
//   wrap      all-ones rollover  tick      FA of the selected stage
module agc_scaler_chain
    import agc_timer_pkg::*;
#(
    parameter int STAGES = SCALER_STAGES_DEFAULT,
    parameter int SELW   = 5
) (
    input  logic              FS01_,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [STAGES-1:0] load_val,
    input  logic [SELW-1:0]   tap_sel,
    output logic [STAGES-1:0] FS,
    output logic [STAGES-1:0] FA,
    output logic [STAGES-1:0] FB,
    output logic              wrap,
    output logic              tick
);
    logic [STAGES-1:0] cnt, nxt, fa_n, fb_n, sel;
    logic              adv;
    assign adv = en & ~load;
    assign nxt = cnt + 1'b1;
    assign FS  = cnt;
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            scaler_edge_det u_det (
                .cur(cnt[k]),
                .nxt(nxt[k]),
                .adv(adv),
                .fa (fa_n[k]),
                .fb (fb_n[k])
            );
            // one-hot decode keeps out-of-range tap_sel values silent
            assign sel[k] = tap_sel == SELW'(k);
        end
    endgenerate
    always_ff @(posedge FS01_) begin
        if (!rst) begin
            cnt  <= '0;
            FA   <= '0;
            FB   <= '0;
            wrap <= 1'b0;
            tick <= 1'b0;
        end else begin
            cnt  <= load ? load_val : adv ? nxt : cnt;
            FA   <= fa_n;
            FB   <= fb_n;
            wrap <= adv & (&cnt);
            tick <= |(fa_n & sel);
        end
    end
endmodule

// File: tb/tb_agc_scaler_chain.sv
`timescale 1ns/1ps
// tb_agc_scaler_chain: table-driven and scoreboard checks of agc_scaler_chain.
module tb_agc_scaler_chain;
    typedef struct packed {
        logic        r, e, l;
        logic [16:0] lv;
        logic [4:0]  ts;
        logic [16:0] fs, fa, fb;
        logic        w, t;
    } vec_t;

    logic        FS01_ = 1'b0;
    logic        rst, en, load;
    logic [16:0] load_val;
    logic [4:0]  tap_sel;
    logic [16:0] FS, FA, FB;
    logic        wrap, tick;

    int          total = 0, passed = 0;
    logic [16:0] m = '0;
    vec_t        exp_q[$];
    vec_t        tv[14];
    int          fa_cnt[17];
    int          tick_cnt;

    always #4883 FS01_ = ~FS01_;

    agc_scaler_chain dut (
        .FS01_(FS01_), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .tap_sel(tap_sel), .FS(FS), .FA(FA), .FB(FB), .wrap(wrap), .tick(tick)
    );

    function automatic vec_t mk(input logic r, e, l, input logic [16:0] lv, input logic [4:0] ts,
                                input logic [16:0] fs, fa, fb, input logic w, t);
        vec_t v;
        v = '{r:r, e:e, l:l, lv:lv, ts:ts, fs:fs, fa:fa, fb:fb, w:w, t:t};
        return v;
    endfunction

    // reference: expected outputs for an un-loaded, non-reset edge from model state m
    function automatic vec_t run(input logic e, input logic [4:0] ts);
        logic [16:0] nm, fa, fb;
        nm = e ? m + 17'd1 : m;
        fa = e ? (~m & nm) : '0;
        fb = e ? (m & ~nm) : '0;
        return mk(1, e, 0, '0, ts, nm, fa, fb, e && (m == 17'h1FFFF), (ts < 17) ? fa[ts] : 1'b0);
    endfunction

    task automatic drive(input vec_t v, input string nm);
        vec_t x;
        rst = v.r; en = v.e; load = v.l; load_val = v.lv; tap_sel = v.ts;
        exp_q.push_back(v);
        @(posedge FS01_);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x = exp_q.pop_front();
            if ({FS, FA, FB, wrap, tick} === {x.fs, x.fa, x.fb, x.w, x.t}) passed++;
            else $display("FAIL %s: got fs=%h fa=%h fb=%h wrap=%b tick=%b, want fs=%h fa=%h fb=%h wrap=%b tick=%b",
                          nm, FS, FA, FB, wrap, tick, x.fs, x.fa, x.fb, x.w, x.t);
        end
        m = v.fs;
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, want);
    endtask

    initial begin
        tv[0]  = mk(0, 1, 0, 17'h0,     20, 17'h0,     17'h0, 17'h0,     0, 0);
        tv[1]  = tv[0];
        tv[2]  = tv[0];
        tv[3]  = mk(1, 1, 0, 17'h0,     0,  17'h1,     17'h1, 17'h0,     0, 1);
        tv[4]  = mk(1, 1, 0, 17'h0,     20, 17'h2,     17'h2, 17'h1,     0, 0);
        tv[5]  = mk(1, 1, 1, 17'h1FFFF, 20, 17'h1FFFF, 17'h0, 17'h0,     0, 0);
        tv[6]  = mk(1, 1, 0, 17'h0,     20, 17'h0,     17'h0, 17'h1FFFF, 1, 0);
        tv[7]  = mk(1, 1, 0, 17'h0,     20, 17'h1,     17'h1, 17'h0,     0, 0);
        tv[8]  = mk(1, 0, 1, 17'h5,     20, 17'h5,     17'h0, 17'h0,     0, 0);
        tv[9]  = mk(1, 1, 0, 17'h0,     20, 17'h6,     17'h2, 17'h1,     0, 0);
        tv[10] = mk(1, 1, 1, 17'h7,     20, 17'h7,     17'h0, 17'h0,     0, 0);
        tv[11] = mk(1, 1, 1, 17'h3,     20, 17'h3,     17'h0, 17'h0,     0, 0);
        tv[12] = mk(0, 1, 1, 17'h3,     20, 17'h0,     17'h0, 17'h0,     0, 0);
        tv[13] = mk(1, 1, 0, 17'h0,     20, 17'h1,     17'h1, 17'h0,     0, 0);
        for (int i = 0; i < 14; i++) begin
            if (i == 9)
                for (int j = 0; j < 10; j++)
                    drive(mk(1, 0, 0, 17'h0, 20, 17'h5, 17'h0, 17'h0, 0, 0), "freeze");
            drive(tv[i], $sformatf("vec%0d", i));
        end
        drive(mk(0, 1, 0, 17'h0, 3, 17'h0, 17'h0, 17'h0, 0, 0), "rerun_reset");
        foreach (fa_cnt[k]) fa_cnt[k] = 0;
        tick_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            drive(run(1, 3), $sformatf("free%0d", i));
            foreach (fa_cnt[k]) fa_cnt[k] += int'(FA[k]);
            if (i < 32) tick_cnt += int'(tick);
        end
        for (int k = 0; k < 6; k++) check_int($sformatf("fa_count%0d", k), fa_cnt[k], 64 >> (k + 1));
        check_int("tick_count_sel3", tick_cnt, 2);
        tick_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            drive(run(1, 20), $sformatf("sel20_%0d", i));
            tick_cnt += int'(tick);
        end
        check_int("tick_count_sel20", tick_cnt, 0);
        drive(run(0, 3), "hold_after_run");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
